sdio_irq_ctrl: RTL and testbench
================================

// Module: sdio_irq_ctrl
// PURPOSE
// - Interrupt delivery controller on top of the SD host flag block: masks the 4 irq flags and
//   7 error flags with host-programmable enables and drives one host interrupt line.
// - Sequences delivery with an ASSERT/ACK handshake, optional hold-off and a delivery counter.
// - Sits between the flag block and the host bus interface, on sd_clk.
// PARAMETERS
// - REG_ADDR_IRQ_EN  default 34  address of irq enable register, bits[3:0]
// - REG_ADDR_ERR_EN  default 35  address of error enable register, bits[6:0]
// - REG_ADDR_HOLDOFF default 36  address of hold-off count register (IRQ_HOLDOFF_EN only)
// - HOLDOFF_W        default 8   hold-off counter width, in bits
// PORTS
// - sd_clk       in   1  clock
// - rstn         in   1  async reset, active-low
// - all_sd_rst   in   1  sync soft reset of the whole SD controller
// - reg_wr       in   1  register write strobe
// - reg_addr     in   8  register address
// - reg_wdata    in   8  register write data
// - irq_flags    in   4  {card_irq, blk_gap_irq, dat_complete_irq, cmd_complete_irq}
// - err_flags    in   7  {dat_end, dat_crc, dat_timeout, cmd_index, cmd_end, cmd_crc, cmd_timeout}
// - host_irq_ack in   1  one-cycle ack from host
// - host_irq     out  1  registered interrupt line to host
// - irq_en       out  4  irq enable register
// - err_en       out  7  error enable register
// - int_status   out  8  {|(err_flags&err_en), 3'b0, irq_flags&irq_en}, combinational
// - irq_cnt      out  8  delivered-interrupt counter, saturates at 8'hFF
// BEHAVIOUR
// - Reset (rstn low): host_irq=0, irq_en=0, err_en=0, irq_cnt=0, holdoff reg=0, state=IDLE.
// - all_sd_rst: state->IDLE, host_irq=0, hold-off counter=0, irq_cnt=0. Enables and holdoff
//   register are kept. all_sd_rst has priority over every other event in the same cycle.
// - Enable writes: reg_wr with addr==REG_ADDR_IRQ_EN loads irq_en<=wdata[3:0];
//   addr==REG_ADDR_ERR_EN loads err_en<=wdata[6:0]. Effective from the next cycle.
// - pending = |(irq_flags&irq_en) | |(err_flags&err_en), combinational.
// - FSM IDLE/ASSERT/HOLDOFF (2-bit encoding):
//   IDLE:    pending -> ASSERT, host_irq<=1, irq_cnt+=1 (sat). Latency: flag high in cycle N,
//            host_irq high in cycle N+1. host_irq_ack in IDLE is ignored.
//   ASSERT:  host_irq_ack -> HOLDOFF (or IDLE, see CONFIGURATION), host_irq<=0.
//            If ~pending and no ack (host cleared flags first) -> IDLE, host_irq<=0, no count.
//            Ack and ~pending in the same cycle: treated as ack.
//   HOLDOFF: counter loads the holdoff value on entry; decrements each cycle; at 0 -> IDLE.
//            holdoff value 0 -> one cycle in HOLDOFF. Flags are not observed in HOLDOFF.
// - A flag still pending after returning to IDLE re-asserts host_irq the next cycle (level).
// - Holdoff register written in HOLDOFF: the running count is kept; new value on next entry.
// CONFIGURATION
// - IRQ_HOLDOFF_EN defined: holdoff register at REG_ADDR_HOLDOFF, HOLDOFF_W bits, reset 0;
//   ASSERT+ack -> HOLDOFF.
// - IRQ_HOLDOFF_EN undefined: no holdoff register or counter; ASSERT+ack -> IDLE directly;
//   HOLDOFF state unreachable. Writes to REG_ADDR_HOLDOFF are ignored.
// STRUCTURE
// - sdio_pkg: FSM state typedef (IDLE/ASSERT/HOLDOFF), register address constants,
//   flag bit-index constants shared with the flag block.
// - Sub-module sdio_irq_holdoff_timer (load, dec, zero flag), instantiated only under
//   IRQ_HOLDOFF_EN. Rest is flat.
// TESTING
// - irq_en=4'b0001, cmd_complete flag rises in cycle 10 -> host_irq=1 in cycle 11, irq_cnt=1,
//   int_status=8'h01.
// - err_en=0, err_flags=7'h04 -> host_irq stays 0, int_status=8'h00; then err_en=7'h04
//   -> host_irq=1 one cycle after the write, int_status=8'h80.
// - ASSERT; host clears flag without ack -> host_irq=0 next cycle, state IDLE, irq_cnt unchanged.
// - IRQ_HOLDOFF_EN, holdoff=5, flag held, ack in cycle 20 -> host_irq 0 for cycles 21..26
//   (6 cycles HOLDOFF, incl. load), re-asserted cycle 27, irq_cnt=2.
// - 300 ack/reassert rounds -> irq_cnt saturates at 8'hFF; all_sd_rst -> irq_cnt=0,
//   host_irq=0, irq_en unchanged.
// - rstn low mid-ASSERT -> all outputs 0 immediately; ack in IDLE has no effect.

Source files
------------

// File: rtl/sdio_pkg.sv
// Shared definitions for the SD host interrupt path: FSM state codes,
// default register addresses and flag bit positions used by the flag block.
package sdio_pkg;

    typedef logic [1:0] irq_state_t;

    localparam irq_state_t ST_IDLE    = 2'd0;
    localparam irq_state_t ST_ASSERT  = 2'd1;
    localparam irq_state_t ST_HOLDOFF = 2'd2;

    localparam int IRQ_FLAG_W = 4;
    localparam int ERR_FLAG_W = 7;

    localparam logic [7:0] ADDR_IRQ_EN  = 8'd34;
    localparam logic [7:0] ADDR_ERR_EN  = 8'd35;
    localparam logic [7:0] ADDR_HOLDOFF = 8'd36;

    localparam int IRQ_CMD_COMPLETE = 0;
    localparam int IRQ_DAT_COMPLETE = 1;
    localparam int IRQ_BLK_GAP      = 2;
    localparam int IRQ_CARD         = 3;

    localparam int ERR_CMD_TIMEOUT = 0;
    localparam int ERR_CMD_CRC     = 1;
    localparam int ERR_CMD_END     = 2;
    localparam int ERR_CMD_INDEX   = 3;
    localparam int ERR_DAT_TIMEOUT = 4;
    localparam int ERR_DAT_CRC     = 5;
    localparam int ERR_DAT_END     = 6;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sdio_irq_holdoff_timer.sv
// Down-counter that spaces out interrupt deliveries; loads a count, steps
// down on request and flags zero. Soft clear wins over load and decrement.
module sdio_irq_holdoff_timer #(
    parameter int W = 8
) (
    input  logic         sd_clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/sdio_irq_ctrl.sv
// Masks SD irq/error flags and delivers a single host interrupt with an ack
// handshake. Define IRQ_HOLDOFF_EN to add the programmable hold-off after each ack.
module sdio_irq_ctrl
    import sdio_pkg::*;
#(
    parameter logic [7:0] REG_ADDR_IRQ_EN  = ADDR_IRQ_EN,
    parameter logic [7:0] REG_ADDR_ERR_EN  = ADDR_ERR_EN,
    parameter logic [7:0] REG_ADDR_HOLDOFF = ADDR_HOLDOFF,
    parameter int         HOLDOFF_W        = 8
) (
    input  logic                  sd_clk,
    input  logic                  rstn,
    input  logic                  all_sd_rst,
    input  logic                  reg_wr,
    input  logic [7:0]            reg_addr,
    input  logic [7:0]            reg_wdata,
    input  logic [IRQ_FLAG_W-1:0] irq_flags,
    input  logic [ERR_FLAG_W-1:0] err_flags,
    input  logic                  host_irq_ack,
    output logic                  host_irq,
    output logic [IRQ_FLAG_W-1:0] irq_en,
    output logic [ERR_FLAG_W-1:0] err_en,
    output logic [7:0]            int_status,
    output logic [7:0]            irq_cnt
);

    irq_state_t            state_q, state_d;
    logic                  host_irq_q, host_irq_d;
    logic [7:0]            irq_cnt_q, irq_cnt_d;
    logic [IRQ_FLAG_W-1:0] irq_en_q, irq_en_d;
    logic [ERR_FLAG_W-1:0] err_en_q, err_en_d;
    logic [IRQ_FLAG_W-1:0] irq_masked;
    logic                  err_any;
    logic                  pending;

`ifdef IRQ_HOLDOFF_EN
    logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
    logic                 tmr_load;
    logic                 tmr_dec;
    logic                 tmr_zero;

    sdio_irq_holdoff_timer #(
        .W (HOLDOFF_W)
    ) u_holdoff_timer (
        .sd_clk   (sd_clk),
        .rstn     (rstn),
        .clr      (all_sd_rst),
        .load     (tmr_load),
        .load_val (holdoff_q),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{reg_wdata[7], REG_ADDR_HOLDOFF, (HOLDOFF_W != 0)};
`endif

    assign irq_masked = irq_flags & irq_en_q;
    assign err_any    = |(err_flags & err_en_q);
    assign pending    = (|irq_masked) | err_any;
    assign int_status = {err_any, 3'b000, irq_masked};

    always_comb begin
        state_d    = state_q;
        host_irq_d = host_irq_q;
        irq_cnt_d  = irq_cnt_q;
        irq_en_d   = irq_en_q;
        err_en_d   = err_en_q;
`ifdef IRQ_HOLDOFF_EN
        holdoff_d  = holdoff_q;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
`endif
        if (all_sd_rst) begin
            state_d    = ST_IDLE;
            host_irq_d = 1'b0;
            irq_cnt_d  = 8'd0;
        end else begin
            if (reg_wr && (reg_addr == REG_ADDR_IRQ_EN)) begin
                irq_en_d = reg_wdata[IRQ_FLAG_W-1:0];
            end
            if (reg_wr && (reg_addr == REG_ADDR_ERR_EN)) begin
                err_en_d = reg_wdata[ERR_FLAG_W-1:0];
            end
`ifdef IRQ_HOLDOFF_EN
            if (reg_wr && (reg_addr == REG_ADDR_HOLDOFF)) begin
                holdoff_d = reg_wdata[HOLDOFF_W-1:0];
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pending) begin
                        state_d    = ST_ASSERT;
                        host_irq_d = 1'b1;
                        irq_cnt_d  = sat_inc8(irq_cnt_q);
                    end
                end
                // Ack wins over a simultaneous flag clear.
                ST_ASSERT: begin
                    if (host_irq_ack) begin
                        host_irq_d = 1'b0;
`ifdef IRQ_HOLDOFF_EN
                        state_d    = ST_HOLDOFF;
                        tmr_load   = 1'b1;
`else
                        state_d    = ST_IDLE;
`endif
                    end else if (!pending) begin
                        state_d    = ST_IDLE;
                        host_irq_d = 1'b0;
                    end
                end
`ifdef IRQ_HOLDOFF_EN
                // Expiry is resolved as IDLE in the same edge, so a level
                // still pending re-asserts without an extra dead cycle.
                ST_HOLDOFF: begin
                    if (!tmr_zero) begin
                        tmr_dec = 1'b1;
                    end else if (pending) begin
                        state_d    = ST_ASSERT;
                        host_irq_d = 1'b1;
                        irq_cnt_d  = sat_inc8(irq_cnt_q);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_d    = ST_IDLE;
                    host_irq_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            host_irq_q <= 1'b0;
            irq_cnt_q  <= 8'd0;
            irq_en_q   <= '0;
            err_en_q   <= '0;
        end else begin
            state_q    <= state_d;
            host_irq_q <= host_irq_d;
            irq_cnt_q  <= irq_cnt_d;
            irq_en_q   <= irq_en_d;
            err_en_q   <= err_en_d;
        end
    end

`ifdef IRQ_HOLDOFF_EN
    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            holdoff_q <= '0;
        end else begin
            holdoff_q <= holdoff_d;
        end
    end
`endif

    assign host_irq = host_irq_q;
    assign irq_en   = irq_en_q;
    assign err_en   = err_en_q;
    assign irq_cnt  = irq_cnt_q;

endmodule

// File: tb/tb_sdio_irq_ctrl.sv
// Directed bench for sdio_irq_ctrl: masking, ack/reassert timing, hold-off
// (when IRQ_HOLDOFF_EN is defined), counter saturation and both resets.
module tb_sdio_irq_ctrl;
    import sdio_pkg::*;

    logic       sd_clk;
    logic       rstn;
    logic       all_sd_rst;
    logic       reg_wr;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [3:0] irq_flags;
    logic [6:0] err_flags;
    logic       host_irq_ack;
    logic       host_irq;
    logic [3:0] irq_en;
    logic [6:0] err_en;
    logic [7:0] int_status;
    logic [7:0] irq_cnt;

    int tests_run;
    int tests_failed;
    logic [7:0] exp_cnt;

    sdio_irq_ctrl dut (
        .sd_clk       (sd_clk),
        .rstn         (rstn),
        .all_sd_rst   (all_sd_rst),
        .reg_wr       (reg_wr),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .irq_flags    (irq_flags),
        .err_flags    (err_flags),
        .host_irq_ack (host_irq_ack),
        .host_irq     (host_irq),
        .irq_en       (irq_en),
        .err_en       (err_en),
        .int_status   (int_status),
        .irq_cnt      (irq_cnt)
    );

    initial sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;

    task automatic tick();
        @(posedge sd_clk);
        #1;
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [7:0] data);
        reg_wr    = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        tick();
        reg_wr    = 1'b0;
        reg_addr  = 8'd0;
        reg_wdata = 8'd0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; all_sd_rst = 1'b0; reg_wr = 1'b0; reg_addr = 8'd0; reg_wdata = 8'd0;
        irq_flags = 4'd0; err_flags = 7'd0; host_irq_ack = 1'b0;
        tick();
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_host_irq: got %b want 0", host_irq); end
        tests_run++; if (irq_en !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_irq_en: got %h want 0", irq_en); end
        tests_run++; if (err_en !== 7'h00) begin tests_failed++; $display("[TB] FAIL reset_err_en: got %h want 0", err_en); end
        tests_run++; if (irq_cnt !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_irq_cnt: got %h want 0", irq_cnt); end
        tests_run++; if (int_status !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_int_status: got %h want 0", int_status); end
        rstn = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_irq_basic();
        reg_write(ADDR_IRQ_EN, 8'h01);
        irq_flags = 4'd1 << IRQ_CMD_COMPLETE;
        #1;
        tests_run++; if (int_status !== 8'h01) begin tests_failed++; $display("[TB] FAIL basic_int_status: got %h want 01", int_status); end
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_latency: got %b want 0", host_irq); end
        tick();
        tests_run++; if (host_irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_assert: got %b want 1", host_irq); end
        tests_run++; if (irq_cnt !== 8'h01) begin tests_failed++; $display("[TB] FAIL basic_cnt: got %h want 01", irq_cnt); end
    endtask

    task automatic test_clear_no_ack();
        irq_flags = 4'd0;
        tick();
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear_deassert: got %b want 0", host_irq); end
        tests_run++; if (irq_cnt !== 8'h01) begin tests_failed++; $display("[TB] FAIL clear_cnt: got %h want 01", irq_cnt); end
        tick();
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear_stays_idle: got %b want 0", host_irq); end
    endtask

    task automatic test_err_enable();
        err_flags = 7'd1 << ERR_CMD_END;
        #1;
        tests_run++; if (int_status !== 8'h00) begin tests_failed++; $display("[TB] FAIL err_masked_status: got %h want 00", int_status); end
        tick();
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_masked_irq: got %b want 0", host_irq); end
        reg_write(ADDR_ERR_EN, 8'h04);
        tests_run++; if (int_status !== 8'h80) begin tests_failed++; $display("[TB] FAIL err_status: got %h want 80", int_status); end
        tests_run++; if (err_en !== 7'h04) begin tests_failed++; $display("[TB] FAIL err_en_reg: got %h want 04", err_en); end
        tick();
        tests_run++; if (host_irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_assert: got %b want 1", host_irq); end
        tests_run++; if (irq_cnt !== 8'h02) begin tests_failed++; $display("[TB] FAIL err_cnt: got %h want 02", irq_cnt); end
    endtask

    task automatic test_ack_reassert();
        host_irq_ack = 1'b1;
        tick();
        host_irq_ack = 1'b0;
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL ack_deassert: got %b want 0", host_irq); end
        tick();
        tests_run++; if (host_irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL ack_reassert: got %b want 1", host_irq); end
        tests_run++; if (irq_cnt !== 8'h03) begin tests_failed++; $display("[TB] FAIL ack_cnt: got %h want 03", irq_cnt); end
        err_flags = 7'd0;
        tick();
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL ack_clear: got %b want 0", host_irq); end
    endtask

    task automatic test_ack_idle();
        host_irq_ack = 1'b1;
        tick();
        host_irq_ack = 1'b0;
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_ack_irq: got %b want 0", host_irq); end
        tests_run++; if (irq_cnt !== 8'h03) begin tests_failed++; $display("[TB] FAIL idle_ack_cnt: got %h want 03", irq_cnt); end
    endtask

`ifdef IRQ_HOLDOFF_EN
    task automatic test_holdoff();
        reg_write(ADDR_HOLDOFF, 8'd5);
        irq_flags = 4'd1 << IRQ_CMD_COMPLETE;
        tick();
        tests_run++; if (host_irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL ho_assert: got %b want 1", host_irq); end
        host_irq_ack = 1'b1;
        tick();
        host_irq_ack = 1'b0;
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL ho_cycle0: got %b want 0", host_irq); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) reg_write(ADDR_HOLDOFF, 8'd1);
            else tick();
            tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL ho_cycle%0d: got %b want 0", i + 1, host_irq); end
        end
        tick();
        tests_run++; if (host_irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL ho_reassert: got %b want 1", host_irq); end
        tests_run++; if (irq_cnt !== 8'h05) begin tests_failed++; $display("[TB] FAIL ho_cnt: got %h want 05", irq_cnt); end
        host_irq_ack = 1'b1;
        tick();
        host_irq_ack = 1'b0;
        tick();
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL ho1_low: got %b want 0", host_irq); end
        tick();
        tests_run++; if (host_irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL ho1_reassert: got %b want 1", host_irq); end
        reg_write(ADDR_HOLDOFF, 8'd0);
        exp_cnt = 8'h06;
    endtask
`else
    task automatic test_holdoff_disabled();
        reg_write(ADDR_HOLDOFF, 8'd5);
        irq_flags = 4'd1 << IRQ_CMD_COMPLETE;
        tick();
        tests_run++; if (host_irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL nho_assert: got %b want 1", host_irq); end
        host_irq_ack = 1'b1;
        tick();
        host_irq_ack = 1'b0;
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL nho_low: got %b want 0", host_irq); end
        tick();
        tests_run++; if (host_irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL nho_reassert: got %b want 1", host_irq); end
        tests_run++; if (irq_cnt !== 8'h05) begin tests_failed++; $display("[TB] FAIL nho_cnt: got %h want 05", irq_cnt); end
        exp_cnt = 8'h05;
    endtask
`endif

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            host_irq_ack = 1'b1;
            tick();
            host_irq_ack = 1'b0;
            tick();
            tests_run++; if (host_irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL sat_round%0d: got %b want 1", i, host_irq); end
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        end
        tests_run++; if (irq_cnt !== exp_cnt) begin tests_failed++; $display("[TB] FAIL sat_cnt: got %h want %h", irq_cnt, exp_cnt); end
        tests_run++; if (irq_cnt !== 8'hFF) begin tests_failed++; $display("[TB] FAIL sat_cnt_ff: got %h want ff", irq_cnt); end
        all_sd_rst = 1'b1;
        tick();
        all_sd_rst = 1'b0;
        tests_run++; if (irq_cnt !== 8'h00) begin tests_failed++; $display("[TB] FAIL soft_rst_cnt: got %h want 00", irq_cnt); end
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL soft_rst_irq: got %b want 0", host_irq); end
        tests_run++; if (irq_en !== 4'h1) begin tests_failed++; $display("[TB] FAIL soft_rst_irq_en: got %h want 1", irq_en); end
        tests_run++; if (err_en !== 7'h04) begin tests_failed++; $display("[TB] FAIL soft_rst_err_en: got %h want 04", err_en); end
        tick();
        tests_run++; if (host_irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL soft_rst_reassert: got %b want 1", host_irq); end
        tests_run++; if (irq_cnt !== 8'h01) begin tests_failed++; $display("[TB] FAIL soft_rst_recount: got %h want 01", irq_cnt); end
    endtask

    task automatic test_rstn_mid_assert();
        #3;
        rstn = 1'b0;
        #1;
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_rst_irq: got %b want 0", host_irq); end
        tests_run++; if (irq_en !== 4'h0) begin tests_failed++; $display("[TB] FAIL async_rst_irq_en: got %h want 0", irq_en); end
        tests_run++; if (err_en !== 7'h00) begin tests_failed++; $display("[TB] FAIL async_rst_err_en: got %h want 0", err_en); end
        tests_run++; if (irq_cnt !== 8'h00) begin tests_failed++; $display("[TB] FAIL async_rst_cnt: got %h want 0", irq_cnt); end
        tests_run++; if (int_status !== 8'h00) begin tests_failed++; $display("[TB] FAIL async_rst_status: got %h want 0", int_status); end
        tick();
        rstn = 1'b1;
        host_irq_ack = 1'b1;
        tick();
        host_irq_ack = 1'b0;
        tick();
        tests_run++; if (host_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_rst_ack_irq: got %b want 0", host_irq); end
        tests_run++; if (irq_cnt !== 8'h00) begin tests_failed++; $display("[TB] FAIL post_rst_ack_cnt: got %h want 0", irq_cnt); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_cnt      = 8'h00;
        test_reset();
        test_irq_basic();
        test_clear_no_ack();
        test_err_enable();
        test_ack_reassert();
        test_ack_idle();
`ifdef IRQ_HOLDOFF_EN
        test_holdoff();
`else
        test_holdoff_disabled();
`endif
        test_saturation();
        test_rstn_mid_assert();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
